// File: rtl/gg_emu_stream_arbiter.sv
// gg_emu_stream_arbiter
// Two-requester NAL stream arbiter in front of the emulation-removal
// datapath. A grant is held for a whole NAL. The granted requester is
// passed straight through with no added latency. After the last word of
// a NAL, FLUSH_WORDS all-0xFF filler words are emitted so that the
// downstream emulation-prevention history cannot run across NAL
// boundaries.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick a requester (bubble cycle, nothing accepted)
// ST_XFER  | pass-through of granted requester until its last word
// ST_FLUSH | emit filler words; completion reported on the final one
module gg_emu_stream_arbiter #(
   parameter int unsigned WIDTH       = 128,
   parameter int unsigned FLUSH_WORDS = 2
) (
   input  logic             clk_i,
   input  logic             reset_ni,

   input  logic [WIDTH-1:0] s0_data_i,
   input  logic             s0_valid_i,
   input  logic             s0_last_i,
   output logic             s0_ready_o,

   input  logic [WIDTH-1:0] s1_data_i,
   input  logic             s1_valid_i,
   input  logic             s1_last_i,
   output logic             s1_ready_o,

   output logic [WIDTH-1:0] m_data_o,
   output logic             m_valid_o,
   output logic             m_last_o,
   output logic             m_flush_o,
   output logic             m_src_o,
   input  logic             m_ready_i,

   output logic             busy_o,
   output logic             nal_done_o,
   output logic [15:0]      nal_words_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_XFER  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   // Filler counter is a down-counter loaded with the filler length;
   // the handshake taken while it reads 1 is the final filler word.
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_WORDS);
   localparam bit         HAS_FLUSH  = (FLUSH_WORDS != 0);

   logic [1:0]       state_q, state_d;
   logic             g_q, g_d;
   logic             lg_q, lg_d;
   logic [15:0]      wc_q, wc_d;
   logic [2:0]       fc_q, fc_d;
   logic             nal_done_q, nal_done_d;
   logic [15:0]      nal_words_q, nal_words_d;

   logic [WIDTH-1:0] sel_data;
   logic             sel_valid;
   logic             sel_last;
   logic             xfer_hs;
   logic             flush_hs;
   logic [15:0]      wc_inc;

   // Selected requester view and handshake qualifiers
   always_comb begin
      sel_data  = g_q ? s1_data_i  : s0_data_i;
      sel_valid = g_q ? s1_valid_i : s0_valid_i;
      sel_last  = g_q ? s1_last_i  : s0_last_i;
      xfer_hs   = (state_q == ST_XFER)  && sel_valid && m_ready_i;
      flush_hs  = (state_q == ST_FLUSH) && m_ready_i;
      // Word count sticks at all-ones so very long NALs read as saturated
      wc_inc    = (wc_q == 16'hFFFF) ? wc_q : (wc_q + 16'd1);
   end

   // Output decode; the datapath sees the granted requester combinationally
   always_comb begin
      m_data_o   = '0;
      m_valid_o  = 1'b0;
      m_last_o   = 1'b0;
      m_flush_o  = 1'b0;
      m_src_o    = 1'b0;
      s0_ready_o = 1'b0;
      s1_ready_o = 1'b0;
      case (state_q)
         ST_XFER: begin
            m_data_o   = sel_data;
            m_valid_o  = sel_valid;
            m_last_o   = sel_last;
            m_src_o    = g_q;
            s0_ready_o = !g_q && m_ready_i;
            s1_ready_o =  g_q && m_ready_i;
         end
         ST_FLUSH: begin
            m_data_o   = '1;
            m_valid_o  = 1'b1;
            m_flush_o  = 1'b1;
            m_src_o    = g_q;
         end
         default: ;
      endcase
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign nal_done_o  = nal_done_q;
   assign nal_words_o = nal_words_q;

   // Next-state: arbitration, word counting, filler sequencing, completion
   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      lg_d        = lg_q;
      wc_d        = wc_q;
      fc_d        = fc_q;
      nal_done_d  = 1'b0;
      nal_words_d = nal_words_q;
      case (state_q)
         ST_IDLE: begin
            if (s0_valid_i || s1_valid_i) begin
               // On a tie the requester that did not finish last wins
               if (s0_valid_i && s1_valid_i) g_d = !lg_q;
               else                          g_d = s1_valid_i;
               wc_d    = 16'd0;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (xfer_hs) begin
               wc_d = wc_inc;
               if (sel_last) begin
                  if (HAS_FLUSH) begin
                     fc_d    = FLUSH_LOAD;
                     state_d = ST_FLUSH;
                  end else begin
                     nal_done_d  = 1'b1;
                     nal_words_d = wc_inc;
                     lg_d        = g_q;
                     state_d     = ST_IDLE;
                  end
               end
            end
         end
         ST_FLUSH: begin
            if (flush_hs) begin
               fc_d = fc_q - 3'd1;
               if (fc_q == 3'd1) begin
                  fc_d        = 3'd0;
                  nal_done_d  = 1'b1;
                  nal_words_d = wc_q;
                  lg_d        = g_q;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; an interrupted NAL is simply dropped on reset
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= ST_IDLE;
         g_q         <= 1'b0;
         lg_q        <= 1'b1;
         wc_q        <= 16'd0;
         fc_q        <= 3'd0;
         nal_done_q  <= 1'b0;
         nal_words_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         lg_q        <= lg_d;
         wc_q        <= wc_d;
         fc_q        <= fc_d;
         nal_done_q  <= nal_done_d;
         nal_words_q <= nal_words_d;
      end
   end

endmodule

// File: tb/tb_gg_emu_stream_arbiter.sv
// Bench for gg_emu_stream_arbiter: randomized requester traffic checked
// every cycle against a NAL-level reference model, plus directed cases.
module tb_gg_emu_stream_arbiter;
   localparam int W = 128;
   typedef logic [159:0] v_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic [W-1:0]  s0_data, s1_data;
   logic          s0_valid, s0_last, s1_valid, s1_last, m_ready;

   // instance with FLUSH_WORDS=2
   logic [W-1:0]  a_data;
   logic          a_s0r, a_s1r, a_mv, a_ml, a_mf, a_src, a_busy, a_done;
   logic [15:0]   a_words;
   // instance with FLUSH_WORDS=0
   logic [W-1:0]  b_data;
   logic          b_s0r, b_s1r, b_mv, b_ml, b_mf, b_src, b_busy, b_done;
   logic [15:0]   b_words;

   logic          sel_b;
   logic [W-1:0]  o_data;
   logic          o_s0r, o_s1r, o_mv, o_ml, o_mf, o_src, o_busy, o_done;
   logic [15:0]   o_words;

   gg_emu_stream_arbiter #(.WIDTH(W), .FLUSH_WORDS(2)) dut_a (
      .clk_i(clk), .reset_ni(reset_n),
      .s0_data_i(s0_data), .s0_valid_i(s0_valid), .s0_last_i(s0_last), .s0_ready_o(a_s0r),
      .s1_data_i(s1_data), .s1_valid_i(s1_valid), .s1_last_i(s1_last), .s1_ready_o(a_s1r),
      .m_data_o(a_data), .m_valid_o(a_mv), .m_last_o(a_ml), .m_flush_o(a_mf), .m_src_o(a_src),
      .m_ready_i(m_ready), .busy_o(a_busy), .nal_done_o(a_done), .nal_words_o(a_words));

   gg_emu_stream_arbiter #(.WIDTH(W), .FLUSH_WORDS(0)) dut_b (
      .clk_i(clk), .reset_ni(reset_n),
      .s0_data_i(s0_data), .s0_valid_i(s0_valid), .s0_last_i(s0_last), .s0_ready_o(b_s0r),
      .s1_data_i(s1_data), .s1_valid_i(s1_valid), .s1_last_i(s1_last), .s1_ready_o(b_s1r),
      .m_data_o(b_data), .m_valid_o(b_mv), .m_last_o(b_ml), .m_flush_o(b_mf), .m_src_o(b_src),
      .m_ready_i(m_ready), .busy_o(b_busy), .nal_done_o(b_done), .nal_words_o(b_words));

   assign o_data  = sel_b ? b_data  : a_data;
   assign o_s0r   = sel_b ? b_s0r   : a_s0r;
   assign o_s1r   = sel_b ? b_s1r   : a_s1r;
   assign o_mv    = sel_b ? b_mv    : a_mv;
   assign o_ml    = sel_b ? b_ml    : a_ml;
   assign o_mf    = sel_b ? b_mf    : a_mf;
   assign o_src   = sel_b ? b_src   : a_src;
   assign o_busy  = sel_b ? b_busy  : a_busy;
   assign o_done  = sel_b ? b_done  : a_done;
   assign o_words = sel_b ? b_words : a_words;

   int n_chk = 0;
   int n_pass = 0;

   // source NAL queues
   logic [W-1:0] q0d[$], q1d[$];
   bit           q0l[$], q1l[$];
   bit           hold[2];
   bit           sv[2], sl[2];
   logic [W-1:0] sd[2];
   int           vprob, rmode;
   bit           mr_t;

   // reference model (NAL-level): 0 = no owner, 1 = streaming NAL, 2 = filler
   int           ph, left, cnt, fw;
   bit           own, lo, e_done;
   logic [15:0]  e_words;

   // observed statistics
   int           n_done_obs, n_flush_obs, first_src_obs;
   logic [15:0]  words_obs;

   task automatic chk(string tag, v_t obs, v_t exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [W-1:0] rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic add_nal(int s, int len);
      logic [W-1:0] d;
      for (int k = 0; k < len; k++) begin
         d = rnd();
         if (s == 0) begin q0d.push_back(d); q0l.push_back(k == len - 1); end
         else        begin q1d.push_back(d); q1l.push_back(k == len - 1); end
      end
   endtask

   task automatic model_reset();
      ph = 0; left = 0; cnt = 0; own = 1'b0; lo = 1'b1;
      e_done = 1'b0; e_words = 16'd0;
   endtask

   task automatic drive();
      bit have;
      for (int i = 0; i < 2; i++) begin
         have = (i == 0) ? (q0d.size() > 0) : (q1d.size() > 0);
         if (!hold[i]) sv[i] = have && ($urandom_range(99) < vprob);
         if (sv[i]) begin
            sd[i] = (i == 0) ? q0d[0] : q1d[0];
            sl[i] = (i == 0) ? q0l[0] : q1l[0];
         end else begin
            sd[i] = rnd();
            sl[i] = 1'($urandom_range(1));
         end
      end
      case (rmode)
         0: m_ready = 1'b1;
         1: begin mr_t = !mr_t; m_ready = mr_t; end
         default: m_ready = 1'($urandom_range(1));
      endcase
      s0_data = sd[0]; s0_valid = sv[0]; s0_last = sl[0];
      s1_data = sd[1]; s1_valid = sv[1]; s1_last = sl[1];
   endtask

   task automatic complete();
      e_done = 1'b1; e_words = 16'(cnt); lo = own; ph = 0;
   endtask

   // compare DUT against the model for this cycle, then advance the model
   task automatic check_and_model();
      logic [5:0] e_ctl;
      bit acc;
      case (ph)
         0: e_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_done};
         1: e_ctl = {sv[own], (own == 1'b0) && m_ready, (own == 1'b1) && m_ready, 1'b0, 1'b1, e_done};
         default: e_ctl = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, e_done};
      endcase
      chk("cyc_ctl{mv,r0,r1,mf,busy,done}", v_t'({o_mv, o_s0r, o_s1r, o_mf, o_busy, o_done}), v_t'(e_ctl));
      chk("cyc_nal_words", v_t'(o_words), v_t'(e_words));
      if (ph == 1) begin
         chk("cyc_xfer_data", v_t'(o_data), v_t'(sd[own]));
         chk("cyc_xfer_last_src", v_t'({o_ml, o_src}), v_t'({sl[own], own}));
      end else if (ph == 2) begin
         chk("cyc_flush_data", v_t'(o_data), v_t'({W{1'b1}}));
         chk("cyc_flush_last_src", v_t'({o_ml, o_src}), v_t'({1'b0, own}));
      end

      if (o_mv && m_ready && o_mf) n_flush_obs++;
      if (o_done) begin n_done_obs++; words_obs = o_words; end
      if (first_src_obs < 0 && o_s0r && s0_valid) first_src_obs = 0;
      if (first_src_obs < 0 && o_s1r && s1_valid) first_src_obs = 1;

      e_done = 1'b0;
      acc = 1'b0;
      case (ph)
         0: if (sv[0] || sv[1]) begin
               own = (sv[0] && sv[1]) ? !lo : sv[1];
               cnt = 0; ph = 1;
            end
         1: if (sv[own] && m_ready) begin
               acc = 1'b1;
               if (cnt < 65535) cnt = cnt + 1;
               if (own == 1'b0) begin void'(q0d.pop_front()); void'(q0l.pop_front()); end
               else             begin void'(q1d.pop_front()); void'(q1l.pop_front()); end
               if (sl[own]) begin
                  if (fw > 0) begin ph = 2; left = fw; end
                  else complete();
               end
            end
         default: if (m_ready) begin
               left = left - 1;
               if (left == 0) complete();
            end
      endcase
      for (int i = 0; i < 2; i++)
         hold[i] = sv[i] && !(acc && (own == 1'(i)));
   endtask

   task automatic cycle();
      drive();
      #1;
      check_and_model();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(string tag);
      chk(tag, v_t'({o_mv, o_ml, o_mf, o_src, o_s0r, o_s1r, o_busy, o_done, o_words}), v_t'(0));
      chk({tag, "_data"}, v_t'(o_data), v_t'(0));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0; s1_last = 1'b0;
      s0_data = '0; s1_data = '0; m_ready = 1'b0;
      q0d.delete(); q0l.delete(); q1d.delete(); q1l.delete();
      hold[0] = 1'b0; hold[1] = 1'b0; sv[0] = 1'b0; sv[1] = 1'b0;
      model_reset();
      n_done_obs = 0; n_flush_obs = 0; first_src_obs = -1; words_obs = 16'd0;
      #1;
      chk_reset_vals("reset_async");
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset_held");
      reset_n = 1'b1;
   endtask

   task automatic run_drain(string tag, int budget);
      int n = 0;
      while ((q0d.size() > 0 || q1d.size() > 0 || ph != 0) && n < budget) begin
         cycle();
         n++;
      end
      chk({tag, "_timeout"}, v_t'(n < budget), v_t'(1));
      cycle();
      cycle();
   endtask

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      sel_b = 1'b0; fw = 2; mr_t = 1'b0;
      vprob = 100; rmode = 0;
      reset_n = 1'b0;

      // both requesters valid at reset release, 3-word NALs
      do_reset();
      add_nal(0, 3); add_nal(1, 3);
      run_drain("tie", 200);
      chk("tie_first_src", v_t'(first_src_obs), v_t'(0));
      chk("tie_done_cnt", v_t'(n_done_obs), v_t'(2));
      chk("tie_nal_words", v_t'(words_obs), v_t'(3));
      chk("tie_flush_cnt", v_t'(n_flush_obs), v_t'(4));

      // long s0 NAL with s1 waiting, then s0 again: grant alternates
      do_reset();
      add_nal(0, 5); add_nal(1, 3); add_nal(0, 2);
      run_drain("hold", 300);
      chk("hold_first_src", v_t'(first_src_obs), v_t'(0));
      chk("hold_done_cnt", v_t'(n_done_obs), v_t'(3));
      chk("hold_nal_words", v_t'(words_obs), v_t'(2));

      // m_ready toggling every cycle
      do_reset();
      rmode = 1;
      add_nal(0, 4); add_nal(1, 6);
      run_drain("toggle", 300);
      chk("toggle_done_cnt", v_t'(n_done_obs), v_t'(2));
      chk("toggle_flush_cnt", v_t'(n_flush_obs), v_t'(4));

      // randomized traffic, gaps on both sides
      do_reset();
      rmode = 2; vprob = 70;
      for (int k = 0; k < 12; k++) add_nal(int'($urandom_range(1)), int'($urandom_range(6, 1)));
      run_drain("rand", 3000);
      chk("rand_done_cnt", v_t'(n_done_obs), v_t'(12));
      chk("rand_flush_cnt", v_t'(n_flush_obs), v_t'(24));

      // reset during the second filler word
      do_reset();
      rmode = 0; vprob = 100;
      add_nal(0, 2);
      n = 0;
      while (!(ph == 2 && left == 1) && n < 100) begin cycle(); n++; end
      chk("rst_mid_reach", v_t'(n < 100), v_t'(1));
      chk("rst_mid_no_done", v_t'(n_done_obs), v_t'(0));
      do_reset();
      add_nal(0, 3); add_nal(1, 3);
      run_drain("rst_mid_after", 200);
      chk("rst_mid_first_src", v_t'(first_src_obs), v_t'(0));
      chk("rst_mid_done_cnt", v_t'(n_done_obs), v_t'(2));

      // FLUSH_WORDS=0 instance: single-word NAL, then random NALs
      sel_b = 1'b1; fw = 0;
      do_reset();
      add_nal(0, 1);
      run_drain("nf1", 100);
      chk("nf1_done_cnt", v_t'(n_done_obs), v_t'(1));
      chk("nf1_nal_words", v_t'(words_obs), v_t'(1));
      chk("nf1_flush_cnt", v_t'(n_flush_obs), v_t'(0));
      rmode = 2; vprob = 80;
      for (int k = 0; k < 8; k++) add_nal(int'($urandom_range(1)), int'($urandom_range(4, 1)));
      run_drain("nf_rand", 1500);
      chk("nf_rand_done_cnt", v_t'(n_done_obs), v_t'(9));
      chk("nf_rand_flush_cnt", v_t'(n_flush_obs), v_t'(0));

      // 70000-word NAL saturates the word count
      sel_b = 1'b0; fw = 2;
      do_reset();
      rmode = 0; vprob = 100;
      add_nal(0, 70000);
      run_drain("sat", 71000);
      chk("sat_done_cnt", v_t'(n_done_obs), v_t'(1));
      chk("sat_nal_words", v_t'(words_obs), v_t'(16'hFFFF));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/gg_emu_stream_arbiter.md
GG_EMU_STREAM_ARBITER -- requirements
Module: gg_emu_stream_arbiter

Interface
REQ-001 Parameter: WIDTH, 128, data word width in bits (16 bytes, big endian byte 0 first).
REQ-002 Parameter: FLUSH_WORDS, 2, filler words inserted after each NAL to purge downstream emulation-removal history (legal 0..7).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 s0_data  in  WIDTH  requester 0 NAL byte stream word.
REQ-006 s0_valid / s0_last  in  1 each  requester 0 word valid; last word of NAL.
REQ-007 s0_ready  out  1  requester 0 word accepted when high with s0_valid.
REQ-008 s1_data, s1_valid, s1_last (in), s1_ready (out): requester 1, identical meaning.
REQ-009 m_data  out  WIDTH  word to emulation-removal datapath.
REQ-010 m_valid / m_last / m_flush  out  1 each  word valid; last NAL word; filler word.
REQ-011 m_src  out  1  index of requester owning the current word.
REQ-012 m_ready  in  1  datapath accepts word when high with m_valid.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 nal_done  out  1  one-cycle pulse per completed NAL (after flush).
REQ-015 nal_words  out  16  data-word count of last completed NAL, held until next nal_done.

Function
REQ-016 States: IDLE, XFER, FLUSH; grant register g (1 bit), last_grant register lg (1 bit).
REQ-017 IDLE: if exactly one sN_valid high, g<=N; if both high, g<=~lg; if none, stay IDLE; any grant moves to XFER next cycle (one-cycle bubble, no word accepted in IDLE).
REQ-018 IDLE outputs: m_valid=0, s0_ready=s1_ready=0, m_flush=0.
REQ-019 XFER: combinational pass-through, zero latency: m_data=s{g}_data, m_valid=s{g}_valid, m_last=s{g}_last, s{g}_ready=m_ready, s{~g}_ready=0, m_src=g, m_flush=0.
REQ-020 XFER: each handshake increments word counter wc (16 bit, saturates at 0xFFFF, never wraps); wc cleared on entry to XFER.
REQ-021 XFER: handshake with m_last=1 -> FLUSH if FLUSH_WORDS>0, else -> IDLE with completion actions of REQ-024.
REQ-022 XFER: deasserted s{g}_valid holds state; grant never changes mid-NAL regardless of other requester.
REQ-023 FLUSH: m_valid=1, m_data=all bytes 0xFF, m_flush=1, m_last=0, m_src=g, both s_ready=0; flush counter counts handshakes; after FLUSH_WORDS handshakes -> IDLE.
REQ-024 Completion (FLUSH exit or last handshake when FLUSH_WORDS=0): nal_words<=wc including last word, nal_done=1 for exactly the following cycle, lg<=g.
REQ-025 m_ready low in FLUSH stalls flush counter; filler word held stable.
REQ-026 m_valid, once asserted in FLUSH, holds until handshake; in XFER stability is requester's responsibility.
REQ-027 Back-to-back NALs from same requester with other idle: IDLE bubble still inserted.

Reset
REQ-028 reset low (any time, including mid-XFER/FLUSH): state=IDLE, g=0, lg=1 (requester 0 wins first tie), wc=0, flush counter=0.
REQ-029 Reset output values: m_valid=0, s0_ready=s1_ready=0, m_last=0, m_flush=0, m_src=0, busy=0, nal_done=0, nal_words=0; m_data=0.
REQ-030 Words in flight at reset are dropped; no nal_done for an interrupted NAL.

Verification
REQ-031 Both requesters valid at reset release, 3-word NALs, m_ready=1, FLUSH_WORDS=2 -> s0 NAL (3 words) then 2 0xFF flush words, nal_done with nal_words=3, IDLE bubble, then s1 NAL, m_src=1.
REQ-032 s0 streams 5 words while s1 valid throughout -> no s1_ready until s0 flush done; grant alternates to s1 next.
REQ-033 m_ready toggled 1/0 every cycle during XFER and FLUSH -> no word lost or duplicated, nal_words=word count, flush words exactly FLUSH_WORDS.
REQ-034 FLUSH_WORDS=0, 1-word NAL -> m_last handshake, next cycle nal_done=1, nal_words=1, no m_flush ever.
REQ-035 reset asserted during 2nd flush word -> next cycle all outputs at REQ-029 values, no nal_done; after release both valid -> s0 granted.
REQ-036 70000-word NAL -> nal_words=0xFFFF (saturated).
